motor_array_controller: RTL

MOTOR_ARRAY_CONTROLLER -- requirements
Module: motor_array_controller

---
 rtl/motor_array_controller_pkg.sv | 25 ++
 rtl/motor_channel.sv | 133 +++++++++++++
 rtl/motor_array_controller.sv | 137 +++++++++++++
 3 files changed

// File: rtl/motor_array_controller_pkg.sv
// Shared constants for the motor array controller: register map,
// CTRL bit layout and the RPM scaling applied to each window count.
package motor_array_controller_pkg;

  localparam int REG_CTRL   = 0;
  localparam int REG_SPEED  = 1;
  localparam int REG_DUTY   = 2;
  localparam int REG_RPM    = 3;
  localparam int REG_STRIDE = 4;

  localparam int CTRL_DIR_LO = 0;
  localparam int CTRL_DIR_HI = 1;
  localparam int CTRL_CLOSED = 2;

  localparam int RPM_SCALE = 157;
  localparam int RPM_SHIFT = 9;

  // Edges per window to RPM; the result never exceeds 78, so bit 7 is 0.
  function automatic logic [7:0] rpm_of(input logic [7:0] cnt);
    logic [15:0] p;
    p = {8'd0, cnt} * 16'(RPM_SCALE);
    return 8'(p >> RPM_SHIFT);
  endfunction

endpackage

// File: rtl/motor_channel.sv
// One motor channel: encoder sync/count, RPM, integrator, PWM compare,
// optional stall detect (MOTOR_STALL_DETECT_EN).
// Ports: clk/rst, strobe, enable, encoder, pwm_tick/pwm_cnt, register
// write strobes + wdata, stall_clr; outputs ctrl/speed/duty/rpm, pwm,
// dir, stall.
module motor_channel
  import motor_array_controller_pkg::*;
#(
  parameter int STALL_WINDOWS = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe,
  input  logic       enable,
  input  logic       encoder,
  input  logic       pwm_tick,
  input  logic [7:0] pwm_cnt,
  input  logic [7:0] wdata,
  input  logic       wr_ctrl,
  input  logic       wr_speed,
  input  logic       wr_duty,
  input  logic       stall_clr,
  output logic [2:0] ctrl,
  output logic [7:0] speed,
  output logic [7:0] duty,
  output logic [7:0] rpm,
  output logic       pwm,
  output logic [1:0] dir,
  output logic       stall
);

  logic       s1, s2, s3;
  logic       edge_det;
  logic [7:0] cnt;
  logic [7:0] rpm_new;
  logic [7:0] err;
  logic signed [9:0] sum;
  logic [7:0] duty_sat;
  logic       closed;
  logic       stall_hit;

  assign edge_det = s2 ^ s3;
  assign closed   = ctrl[CTRL_CLOSED];
  assign dir      = ctrl[CTRL_DIR_HI:CTRL_DIR_LO];
  // The controller acts on the measurement that closes this window.
  assign rpm_new  = rpm_of(cnt);
  assign err      = speed - rpm_new;
  assign sum      = $signed({2'b00, duty})
                  + $signed({{2{err[7]}}, err});

  always_comb begin
    duty_sat = sum[7:0];
    if (sum < 10'sd0)
      duty_sat = 8'h00;
    else if (sum > 10'sd255)
      duty_sat = 8'hFF;
  end

`ifdef MOTOR_STALL_DETECT_EN
  logic [7:0] streak;
  logic       starved;

  assign starved   = closed && duty == 8'hFF && cnt == 8'h00;
  assign stall_hit = strobe && starved
                  && streak == 8'(STALL_WINDOWS - 1);

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= '0;
      stall  <= 1'b0;
    end else begin
      if (strobe)
        streak <= (starved && !stall_hit) ? streak + 8'd1 : 8'd0;
      if (stall_hit)
        stall <= 1'b1;
      else if (stall_clr)
        stall <= 1'b0;
    end
  end
`else
  logic unused_stall_clr;
  assign unused_stall_clr = stall_clr;
  assign stall_hit = 1'b0;
  assign stall     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      cnt   <= '0;
      rpm   <= '0;
      ctrl  <= '0;
      speed <= '0;
      duty  <= '0;
      pwm   <= 1'b0;
    end else begin
      s1 <= encoder;
      s2 <= s1;
      s3 <= s2;
      // An edge landing on the strobe belongs to the new window.
      if (strobe) begin
        rpm <= rpm_new;
        cnt <= {7'd0, edge_det};
      end else if (edge_det && cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (wr_ctrl)
        ctrl <= wdata[2:0];
      if (wr_speed)
        speed <= {1'b0, wdata[6:0]};
      if (stall_hit) begin
        duty              <= 8'h00;
        ctrl[CTRL_CLOSED] <= 1'b0;
      end else if (strobe && closed) begin
        duty <= duty_sat;
      end else if (wr_duty && !closed) begin
        duty <= wdata;
      end
      // Wrap check first so DUTY=255 never drops.
      if (!enable)
        pwm <= 1'b0;
      else if (pwm_tick) begin
        if (pwm_cnt == 8'hFF)
          pwm <= 1'b1;
        else if (pwm_cnt == duty)
          pwm <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_array_controller.sv
// Motor array controller top: bus decode, PWM prescaler/counter,
// sample strobe, CHANNELS x motor_channel. Stall detect needs
// MOTOR_STALL_DETECT_EN; otherwise STATUS reads 0.
// Ports: clk, rst, din/address/w_en/r_en/dout bus, encoders, pwm,
// motor (dir pairs), enable.
module motor_array_controller
  import motor_array_controller_pkg::*;
#(
  parameter logic [7:0] BASE_ADDRESS  = 8'h00,
  parameter int         CHANNELS      = 2,
  parameter int         CPU_FREQ      = 16000000,
  parameter int         SAMPLE_HZ     = 10,
  parameter int         PWM_PRESCALE  = 125,
  parameter int         STALL_WINDOWS = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              din,
  input  logic [7:0]              address,
  input  logic                    w_en,
  input  logic                    r_en,
  output logic [7:0]              dout,
  input  logic [CHANNELS-1:0]     encoders,
  output logic [CHANNELS-1:0]     pwm,
  output logic [2*CHANNELS-1:0]   motor,
  output logic                    enable
);

  localparam int          WIN      = CPU_FREQ / SAMPLE_HZ;
  localparam logic [31:0] WIN_LAST = 32'(WIN - 1);
  localparam logic [15:0] PRE_LAST = 16'(PWM_PRESCALE);
  localparam logic [7:0]  A_ENABLE = 8'(REG_STRIDE * CHANNELS);
  localparam logic [7:0]  A_STATUS = 8'(REG_STRIDE * CHANNELS + 1);

  logic [31:0] timer;
  logic        strobe;
  logic [15:0] presc;
  logic        pwm_tick;
  logic [7:0]  pwm_cnt;
  logic        en_q;
  logic [7:0]  addr_off;
  logic [7:0]  rdata;

  logic [CHANNELS-1:0] wr_ctrl;
  logic [CHANNELS-1:0] wr_speed;
  logic [CHANNELS-1:0] wr_duty;
  logic [CHANNELS-1:0] stall_clr;
  logic [CHANNELS-1:0] stall;
  logic [2:0]          ctrl_q  [CHANNELS];
  logic [7:0]          speed_q [CHANNELS];
  logic [7:0]          duty_q  [CHANNELS];
  logic [7:0]          rpm_q   [CHANNELS];

  assign strobe   = timer == WIN_LAST;
  assign pwm_tick = presc == PRE_LAST;
  assign addr_off = address - BASE_ADDRESS;
  assign enable   = en_q;

  always_comb begin
    wr_ctrl   = '0;
    wr_speed  = '0;
    wr_duty   = '0;
    stall_clr = '0;
    rdata     = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (addr_off == 8'(REG_STRIDE * c + REG_CTRL)) begin
        wr_ctrl[c] = w_en;
        rdata      = {5'd0, ctrl_q[c]};
      end
      if (addr_off == 8'(REG_STRIDE * c + REG_SPEED)) begin
        wr_speed[c] = w_en;
        rdata       = speed_q[c];
      end
      if (addr_off == 8'(REG_STRIDE * c + REG_DUTY)) begin
        wr_duty[c] = w_en;
        rdata      = duty_q[c];
      end
      if (addr_off == 8'(REG_STRIDE * c + REG_RPM))
        rdata = rpm_q[c];
    end
    if (addr_off == A_ENABLE)
      rdata = {7'd0, en_q};
    if (addr_off == A_STATUS) begin
      rdata     = 8'(stall);
      stall_clr = din[CHANNELS-1:0] & {CHANNELS{w_en}};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer   <= '0;
      presc   <= '0;
      pwm_cnt <= '0;
      en_q    <= 1'b0;
      dout    <= '0;
    end else begin
      timer <= strobe ? 32'd0 : timer + 32'd1;
      if (pwm_tick) begin
        presc   <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        presc <= presc + 16'd1;
      end
      if (w_en && addr_off == A_ENABLE)
        en_q <= din[0];
      if (r_en)
        dout <= rdata;
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    motor_channel #(
      .STALL_WINDOWS(STALL_WINDOWS)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .strobe   (strobe),
      .enable   (en_q),
      .encoder  (encoders[c]),
      .pwm_tick (pwm_tick),
      .pwm_cnt  (pwm_cnt),
      .wdata    (din),
      .wr_ctrl  (wr_ctrl[c]),
      .wr_speed (wr_speed[c]),
      .wr_duty  (wr_duty[c]),
      .stall_clr(stall_clr[c]),
      .ctrl     (ctrl_q[c]),
      .speed    (speed_q[c]),
      .duty     (duty_q[c]),
      .rpm      (rpm_q[c]),
      .pwm      (pwm[c]),
      .dir      (motor[2*c +: 2]),
      .stall    (stall[c])
    );
  end

endmodule
